adder_pipelined_nbit: RTL and testbench
=======================================

Name: adder_pipelined_nbit

Overview:
- Parametrised, pipelined add/subtract unit.
- Splits a BIT_WIDTH carry chain into NUM_STAGES registered chunks, so throughput is one operation per clock at a shorter critical path.
- Uses a valid/ready handshake on input and output, and reports both unsigned carry/borrow and signed overflow.
- Sits between operand sources and result consumers in datapaths where a flat ripple adder is too slow.

Parameters:
- BIT_WIDTH, 16, operand and result width in bits. Must be an integer multiple of NUM_STAGES.
- NUM_STAGES, 4, number of pipeline stages; also the latency in cycles. Minimum 1.

Ports:
- clk  input  1  system clock, rising edge.
- n_rst  input  1  reset: synchronous, active-low (sampled on rising clk).
- in_valid  input  1  operand beat present.
- in_ready  output  1  unit accepts a beat this cycle.
- a  input  BIT_WIDTH  operand A.
- b  input  BIT_WIDTH  operand B.
- carry_in  input  1  carry (add) or borrow (sub) into the LSB.
- op  input  1  op_t: OP_ADD=0, OP_SUB=1.
- out_valid  output  1  result beat present.
- out_ready  input  1  consumer accepts the result.
- sum  output  BIT_WIDTH  result.
- carry_out  output  1  OP_ADD: carry out of the MSB. OP_SUB: borrow (inverted MSB carry).
- overflow  output  1  signed two's-complement overflow.

Behaviour:
- Chunk width C = BIT_WIDTH/NUM_STAGES. Stage k adds bits [k*C +: C] using the registered carry from stage k-1. Stage 0 uses cin0.
- Operand preparation at input:
  - OP_ADD: b_eff = b, cin0 = carry_in; result is a+b+carry_in.
  - OP_SUB: b_eff = ~b, cin0 = ~carry_in; result is a-b-carry_in.
- Skewing:
  - Upper operand chunks are delayed through stage registers alongside the carry.
  - Completed lower sum chunks are forwarded, so all chunks of one beat emerge together.
- Flags are computed in the final stage:
  - carry_out = c_final XOR (op==OP_SUB).
  - overflow = (a[MSB]==b_eff[MSB]) AND (sum[MSB]!=a[MSB]).
  - a[MSB] and b_eff[MSB] are carried down the pipe for this purpose.
- Pipeline control:
  - adv = ~out_valid | out_ready.
  - in_ready = adv.
  - A beat is accepted when in_valid & in_ready.
  - When adv=1, all stages shift by one and each stage's valid bit takes the previous stage's valid (stage 0 takes in_valid).
  - When adv=0, all stage registers, including outputs, hold.
- Latency: a beat accepted at edge t is presented on out_valid/sum after edge t+NUM_STAGES-1 when there is no stall. Each stall cycle adds one cycle.
- Throughput: 1 beat/cycle when out_ready is held high. Bubbles (in_valid=0) propagate as valid=0 slots.
- Outputs are registered. sum, carry_out and overflow are stable while out_valid=1 and out_ready=0.
- Reset: on a rising clk with n_rst=0, all valid bits clear and all data and flag registers clear to 0. This gives out_valid=0, sum=0, carry_out=0, overflow=0, and in_ready=1 on the following cycle. In-flight beats are discarded, with no partial results after reset.
- Simultaneous events:
  - n_rst=0 overrides any handshake.
  - out_ready and in_valid in the same cycle with a full pipe: the output is consumed and a new beat is accepted in that same cycle.
- NUM_STAGES=1: a single registered full-width adder with latency 1.
- Assertions, in simulation only: when in_valid=1, a, b, carry_in and op contain no X/Z. sum[C-1:0] of stage 0 equals the low chunk of (a+b_eff+cin0).

Decomposition:
- Package adder_pkg: typedef enum logic op_t {OP_ADD, OP_SUB}.
- Sub-module add_chunk_stage, parameter CHUNK_W:
  - Inputs: one C-bit add with carry-in, enable=adv, and the valid bit.
  - Registers: chunk sum, carry-out and valid.
  - Instantiated NUM_STAGES times in a generate loop.
  - Operand and sum skew registers live in the top level.

Test Plan:
All scenarios use the default configuration (BIT_WIDTH=16, NUM_STAGES=4) with out_ready=1 unless stated.
- Carry across a chunk boundary: ADD a=0x00FF, b=0x0001, cin=0. After 4 cycles: out_valid=1, sum=0x0100, carry_out=0, overflow=0.
- Unsigned wrap: ADD a=0xFFFF, b=0x0001, cin=0. Result: sum=0x0000, carry_out=1, overflow=0.
- Signed overflow: ADD a=0x7FFF, b=0x0001. Result: sum=0x8000, overflow=1, carry_out=0. Also SUB a=0x8000, b=0x0001, giving sum=0x7FFF, overflow=1.
- Subtract with borrow:
  - SUB a=0x0005, b=0x0007, cin=0 gives sum=0xFFFE, carry_out=1, overflow=0.
  - SUB a=0x0007, b=0x0005, cin=1 gives sum=0x0001, carry_out=0.
- Backpressure: stream 8 beats (a=i, b=0x1000) back-to-back and drop out_ready for 3 cycles once the first result is valid. Required:
  - in_ready=0 during the stall.
  - Held outputs do not change.
  - All 8 results, i+0x1000 in order, appear with no loss or duplication.
- Reset mid-operation: with 3 beats in flight, drive n_rst=0 for one edge. Required:
  - Next cycle: out_valid=0, sum=0, in_ready=1.
  - None of the 3 beats ever appears.
  - A new beat issued afterwards returns its correct result after 4 cycles.

Source files
------------

// File: rtl/adder_pkg.sv
// Shared types for the pipelined add/subtract unit.
package adder_pkg;

  typedef enum logic {
    OP_ADD = 1'b0,
    OP_SUB = 1'b1
  } op_t;

endpackage

// File: rtl/adder_pipelined_nbit_stage.sv
// One pipeline slice: a CHUNK_W-bit add with carry-in, registering the chunk
// sum, its carry-out and the beat's valid bit whenever the pipe advances.
module add_chunk_stage #(
  parameter int unsigned CHUNK_W = 4
) (
  input  logic               clk,
  input  logic               n_rst,
  input  logic               en,
  input  logic [CHUNK_W-1:0] a_i,
  input  logic [CHUNK_W-1:0] b_i,
  input  logic               c_i,
  input  logic               v_i,
  output logic [CHUNK_W-1:0] sum_o,
  output logic               c_o,
  output logic               v_o
);

  logic [CHUNK_W-1:0] sum_d, sum_q;
  logic               c_d, c_q;
  logic               v_d, v_q;

  always_comb begin
    {c_d, sum_d} = {1'b0, a_i} + {1'b0, b_i} + {{CHUNK_W{1'b0}}, c_i};
    v_d          = v_i;
  end

  always_ff @(posedge clk) begin
    if (!n_rst) begin
      sum_q <= '0;
      c_q   <= 1'b0;
      v_q   <= 1'b0;
    end else if (en) begin
      sum_q <= sum_d;
      c_q   <= c_d;
      v_q   <= v_d;
    end
  end

  always_comb begin
    sum_o = sum_q;
    c_o   = c_q;
    v_o   = v_q;
  end

endmodule

// File: rtl/adder_pipelined_nbit.sv
// Pipelined BIT_WIDTH add/subtract split into NUM_STAGES registered carry
// chunks, with valid/ready flow control and carry/borrow and overflow flags.
module adder_pipelined_nbit
  import adder_pkg::*;
#(
  parameter int unsigned BIT_WIDTH  = 16,
  parameter int unsigned NUM_STAGES = 4
) (
  input  logic                 clk,
  input  logic                 n_rst,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [BIT_WIDTH-1:0] a,
  input  logic [BIT_WIDTH-1:0] b,
  input  logic                 carry_in,
  input  op_t                  op,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [BIT_WIDTH-1:0] sum,
  output logic                 carry_out,
  output logic                 overflow
);

  localparam int unsigned C = BIT_WIDTH / NUM_STAGES;

  logic                 adv;
  logic [BIT_WIDTH-1:0] b_eff;
  logic                 cin0;
  logic [C-1:0]         chunk0_ref;
  logic                 a_msb, b_msb;

  logic [C-1:0]         ch_a  [NUM_STAGES];
  logic [C-1:0]         ch_b  [NUM_STAGES];
  logic                 ch_c  [NUM_STAGES];
  logic                 ch_v  [NUM_STAGES];
  logic [C-1:0]         ch_s  [NUM_STAGES];
  logic                 ch_co [NUM_STAGES];
  logic                 ch_vo [NUM_STAGES];

  // Skew registers: full operands travel with each stage; s_q holds the
  // already-finished low chunks so every chunk of a beat leaves together.
  logic [BIT_WIDTH-1:0] a_d    [NUM_STAGES];
  logic [BIT_WIDTH-1:0] a_q    [NUM_STAGES];
  logic [BIT_WIDTH-1:0] b_d    [NUM_STAGES];
  logic [BIT_WIDTH-1:0] b_q    [NUM_STAGES];
  logic [BIT_WIDTH-1:0] s_d    [NUM_STAGES];
  logic [BIT_WIDTH-1:0] s_q    [NUM_STAGES];
  logic [BIT_WIDTH-1:0] s_full [NUM_STAGES];
  op_t                  op_d   [NUM_STAGES];
  op_t                  op_q   [NUM_STAGES];

  always_comb begin
    b_eff      = (op == OP_SUB) ? ~b : b;
    cin0       = (op == OP_SUB) ? ~carry_in : carry_in;
    chunk0_ref = C'(a + b_eff + BIT_WIDTH'(cin0));
    adv        = ~ch_vo[NUM_STAGES-1] | out_ready;

    for (int unsigned k = 0; k < NUM_STAGES; k++) begin
      s_full[k] = s_q[k] | (BIT_WIDTH'(ch_s[k]) << (k * C));
    end

    a_d[0]  = a;
    b_d[0]  = b_eff;
    op_d[0] = op;
    s_d[0]  = '0;
    ch_c[0] = cin0;
    ch_v[0] = in_valid;
    for (int unsigned k = 1; k < NUM_STAGES; k++) begin
      a_d[k]  = a_q[k-1];
      b_d[k]  = b_q[k-1];
      op_d[k] = op_q[k-1];
      s_d[k]  = s_full[k-1];
      ch_c[k] = ch_co[k-1];
      ch_v[k] = ch_vo[k-1];
    end

    for (int unsigned k = 0; k < NUM_STAGES; k++) begin
      ch_a[k] = C'(a_d[k] >> (k * C));
      ch_b[k] = C'(b_d[k] >> (k * C));
    end

    a_msb     = 1'(a_q[NUM_STAGES-1] >> (BIT_WIDTH - 1));
    b_msb     = 1'(b_q[NUM_STAGES-1] >> (BIT_WIDTH - 1));
    in_ready  = adv;
    out_valid = ch_vo[NUM_STAGES-1];
    sum       = s_full[NUM_STAGES-1];
    carry_out = ch_co[NUM_STAGES-1] ^ (op_q[NUM_STAGES-1] == OP_SUB);
    overflow  = (a_msb == b_msb) && (sum[BIT_WIDTH-1] != a_msb);
  end

  always_ff @(posedge clk) begin
    if (!n_rst) begin
      for (int unsigned k = 0; k < NUM_STAGES; k++) begin
        a_q[k]  <= '0;
        b_q[k]  <= '0;
        s_q[k]  <= '0;
        op_q[k] <= OP_ADD;
      end
    end else if (adv) begin
      for (int unsigned k = 0; k < NUM_STAGES; k++) begin
        a_q[k]  <= a_d[k];
        b_q[k]  <= b_d[k];
        s_q[k]  <= s_d[k];
        op_q[k] <= op_d[k];
      end
    end
  end

  for (genvar k = 0; k < NUM_STAGES; k++) begin : g_stage
    add_chunk_stage #(
      .CHUNK_W(C)
    ) u_stage (
      .clk   (clk),
      .n_rst (n_rst),
      .en    (adv),
      .a_i   (ch_a[k]),
      .b_i   (ch_b[k]),
      .c_i   (ch_c[k]),
      .v_i   (ch_v[k]),
      .sum_o (ch_s[k]),
      .c_o   (ch_co[k]),
      .v_o   (ch_vo[k])
    );
  end

  a_in_known: assert property (@(posedge clk) disable iff (!n_rst)
    in_valid |-> !$isunknown({a, b, carry_in, op}));

  a_chunk0_sum: assert property (@(posedge clk) disable iff (!n_rst)
    (in_valid && adv) |=> (ch_s[0] == $past(chunk0_ref)));

endmodule

// File: tb/tb_adder_pipelined_nbit.sv
// Bench for adder_pipelined_nbit: directed corner cases, backpressure, reset
// mid-flight and randomized traffic against an arithmetic scoreboard.
module tb_adder_pipelined_nbit;
  import adder_pkg::*;

  localparam int unsigned W = 16;
  localparam int unsigned N = 4;

  logic         clk = 1'b0;
  logic         n_rst;
  logic         in_valid, in_ready;
  logic [W-1:0] a, b, sum;
  logic         carry_in;
  op_t          op;
  logic         out_valid, out_ready;
  logic         carry_out, overflow;

  int           n_chk  = 0;
  int           n_fail = 0;
  logic [17:0]  exp_q[$];

  always #5 clk = ~clk;

  adder_pipelined_nbit #(
    .BIT_WIDTH  (W),
    .NUM_STAGES (N)
  ) dut (
    .clk       (clk),
    .n_rst     (n_rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .a         (a),
    .b         (b),
    .carry_in  (carry_in),
    .op        (op),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .sum       (sum),
    .carry_out (carry_out),
    .overflow  (overflow)
  );

  // Reference: true integer arithmetic, returned as {overflow, carry_out, sum}.
  function automatic logic [17:0] model(input logic [15:0] x, input logic [15:0] y,
                                        input logic c, input op_t o);
    int          ur, sr;
    logic        co, ov;
    logic [15:0] s;
    if (o == OP_ADD) begin
      ur = int'(x) + int'(y) + int'(c);
      sr = int'($signed(x)) + int'($signed(y)) + int'(c);
      co = (ur > 65535);
    end else begin
      ur = int'(x) - int'(y) - int'(c);
      sr = int'($signed(x)) - int'($signed(y)) - int'(c);
      co = (ur < 0);
    end
    s  = ur[15:0];
    ov = (sr > 32767) || (sr < -32768);
    return {ov, co, s};
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Advance one clock; handshakes are sampled at the falling edge and the
  // scoreboard is updated, inputs may then be changed 1ns after the rise.
  task automatic tick(output bit acc, output bit cons);
    logic [17:0] e;
    @(negedge clk);
    acc  = (n_rst === 1'b1) && (in_valid === 1'b1) && (in_ready === 1'b1);
    cons = (n_rst === 1'b1) && (out_valid === 1'b1) && (out_ready === 1'b1);
    if (n_rst !== 1'b1) begin
      exp_q.delete();
    end else begin
      if (cons) begin
        if (exp_q.size() == 0) begin
          check("spurious_out", 32'(out_valid), 32'd0);
        end else begin
          e = exp_q.pop_front();
          check("result", {14'd0, overflow, carry_out, sum}, {14'd0, e});
        end
      end
      if (acc) exp_q.push_back(model(a, b, carry_in, op));
    end
    @(posedge clk);
    #1;
  endtask

  task automatic step();
    bit x, y;
    tick(x, y);
  endtask

  task automatic run_dir(input string tag, input logic [15:0] aa, input logic [15:0] bb,
                         input logic cc, input op_t oo, input logic [15:0] es,
                         input logic eco, input logic eov);
    bit acc, cons;
    a = aa; b = bb; carry_in = cc; op = oo; in_valid = 1'b1;
    tick(acc, cons);
    check({tag, "_accept"}, 32'(acc), 32'd1);
    in_valid = 1'b0;
    step();
    step();
    check({tag, "_early"}, 32'(out_valid), 32'd0);
    step();
    check({tag, "_valid"}, 32'(out_valid), 32'd1);
    check({tag, "_sum"}, 32'(sum), 32'(es));
    check({tag, "_flags"}, {30'd0, carry_out, overflow}, {30'd0, eco, eov});
    step();
  endtask

  initial begin
    bit          acc, cons, stalled;
    int          issued, consumed;
    logic [18:0] held;

    n_rst = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
    a = '0; b = '0; carry_in = 1'b0; op = OP_ADD;
    step();
    step();
    check("reset_out", {12'd0, out_valid, carry_out, overflow, sum}, 32'd0);
    check("reset_in_ready", 32'(in_ready), 32'd1);
    n_rst = 1'b1;
    out_ready = 1'b1;

    run_dir("chunk_carry", 16'h00FF, 16'h0001, 1'b0, OP_ADD, 16'h0100, 1'b0, 1'b0);
    run_dir("wrap",        16'hFFFF, 16'h0001, 1'b0, OP_ADD, 16'h0000, 1'b1, 1'b0);
    run_dir("sovf_add",    16'h7FFF, 16'h0001, 1'b0, OP_ADD, 16'h8000, 1'b0, 1'b1);
    run_dir("sovf_sub",    16'h8000, 16'h0001, 1'b0, OP_SUB, 16'h7FFF, 1'b0, 1'b1);
    run_dir("sub_borrow",  16'h0005, 16'h0007, 1'b0, OP_SUB, 16'hFFFE, 1'b1, 1'b0);
    run_dir("sub_cin",     16'h0007, 16'h0005, 1'b1, OP_SUB, 16'h0001, 1'b0, 1'b0);

    // Backpressure: 8 back-to-back beats with a 3-cycle consumer stall.
    issued = 0; consumed = 0; stalled = 1'b0;
    a = '0; b = 16'h1000; carry_in = 1'b0; op = OP_ADD; in_valid = 1'b1;
    for (int cyc = 0; cyc < 60 && consumed < 8; cyc++) begin
      tick(acc, cons);
      if (acc) issued++;
      if (cons) consumed++;
      if (!stalled && out_valid) begin
        stalled = 1'b1;
        held = {out_valid, carry_out, overflow, sum};
        out_ready = 1'b0;
        for (int s = 0; s < 3; s++) begin
          tick(acc, cons);
          if (acc) issued++;
          check("bp_in_ready", 32'(in_ready), 32'd0);
          check("bp_hold", 32'({out_valid, carry_out, overflow, sum}), 32'(held));
        end
        out_ready = 1'b1;
      end
      a = 16'(issued);
      in_valid = (issued < 8);
    end
    in_valid = 1'b0;
    check("bp_count", 32'(consumed), 32'd8);
    check("bp_drained", 32'(exp_q.size()), 32'd0);

    // Reset with three beats in flight.
    in_valid = 1'b1;
    for (int i = 0; i < 3; i++) begin
      a = 16'($urandom); b = 16'($urandom); carry_in = 1'($urandom); op = op_t'($urandom_range(0, 1));
      tick(acc, cons);
    end
    in_valid = 1'b0;
    out_ready = 1'b0;
    n_rst = 1'b0;
    step();
    n_rst = 1'b1;
    check("rst_mid_out", {12'd0, out_valid, carry_out, overflow, sum}, 32'd0);
    check("rst_mid_in_ready", 32'(in_ready), 32'd1);
    out_ready = 1'b1;
    for (int i = 0; i < 8; i++) step();
    check("rst_no_ghost", 32'(out_valid), 32'd0);
    run_dir("post_rst", 16'h1234, 16'h0F0F, 1'b1, OP_ADD, 16'h2144, 1'b0, 1'b0);

    // Randomized traffic with random bubbles and consumer stalls.
    for (int i = 0; i < 400; i++) begin
      in_valid  = ($urandom_range(0, 3) != 0);
      out_ready = ($urandom_range(0, 3) != 0);
      a = 16'($urandom); b = 16'($urandom);
      carry_in = 1'($urandom);
      op = op_t'($urandom_range(0, 1));
      tick(acc, cons);
    end
    in_valid = 1'b0;
    out_ready = 1'b1;
    for (int i = 0; i < 20 && exp_q.size() != 0; i++) step();
    check("rand_drained", 32'(exp_q.size()), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
